// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cfg_pkg
//  Description : Shared constants, state encoding and helpers for the sensor
//                register-programming sequencer. States RDREQ/RDWAIT exist
//                only when I2C_CFG_READBACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

    // Sensor registers that need a settle delay after being written
    localparam logic [15:0] REG_SOFT_RST = 16'h0103;
    localparam logic [15:0] REG_STREAM   = 16'h0100;

    // Sequencer state encoding
    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] ST_PWRUP  = 4'd1;
    localparam logic [STATE_W-1:0] ST_FETCH  = 4'd2;
    localparam logic [STATE_W-1:0] ST_REQ    = 4'd3;
    localparam logic [STATE_W-1:0] ST_WAIT   = 4'd4;
    localparam logic [STATE_W-1:0] ST_SETTLE = 4'd5;
    localparam logic [STATE_W-1:0] ST_NEXT   = 4'd6;
    localparam logic [STATE_W-1:0] ST_DONE   = 4'd7;
    localparam logic [STATE_W-1:0] ST_ERR    = 4'd8;
`ifdef I2C_CFG_READBACK_EN
    localparam logic [STATE_W-1:0] ST_RDREQ  = 4'd9;
    localparam logic [STATE_W-1:0] ST_RDWAIT = 4'd10;
`endif

    // Soft reset always settles; stream register settles only when turning streaming on
    function automatic logic needs_settle(input logic [15:0] addr, input logic [7:0] data);
        return (addr == REG_SOFT_RST) ||
               ((addr == REG_STREAM) && ((data & 8'h01) != 8'h00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_delay_cnt
//  Description : Loadable down-counter shared by the power-up wait and the
//                post-write settle delay. expire is high while the count is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_delay_cnt #(
    parameter int DLY_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DLY_W-1:0] load_val,
    output logic             expire
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // Load on start, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DLY_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cfg_sequencer
//  Description : Walks the sensor config LUT and issues each entry as a
//                16-bit-address I2C write, with power-up wait, settle delays
//                after soft-reset/stream-on, NACK retries and done/error
//                reporting. Define I2C_CFG_READBACK_EN to read back and
//                verify every non-settling write.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int PWRUP_CYC  = CLK_FREQ / 50,
    parameter int SETTLE_CYC = CLK_FREQ / 100,
    parameter int MAX_RETRY  = 3,
    parameter int DLY_W      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  lut_index,
    input  logic [23:0] lut_data,
    input  logic [7:0]  lut_size,
    output logic        i2c_req,
    input  logic        i2c_ack,
    output logic        i2c_rd,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [7:0]  i2c_rdata,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_index
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [DLY_W-1:0]   PWRUP_LD  = DLY_W'(PWRUP_CYC - 1);
    localparam logic [DLY_W-1:0]   SETTLE_LD = DLY_W'(SETTLE_CYC - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [7:0]         size_q, size_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         err_index_q, err_index_d;
    logic               cfg_done_q, cfg_done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               w_restart;
    logic               w_retry_ok;
    logic               w_dly_start;
    logic [DLY_W-1:0]   w_dly_val;
    logic               w_dly_expire;

    // start is honoured only when no sequence is running
    assign w_restart  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERR));
    assign w_retry_ok = (retry_q < RETRY_MAX);

    cfg_delay_cnt #(
        .DLY_W (DLY_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .start    (w_dly_start),
        .load_val (w_dly_val),
        .expire   (w_dly_expire)
    );

    // Next-state and datapath logic for the sequencer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        size_d      = size_q;
        addr_d      = addr_q;
        data_d      = data_q;
        retry_d     = retry_q;
        err_index_d = err_index_q;
        cfg_done_d  = cfg_done_q;
        cfg_err_d   = cfg_err_q;
        w_dly_start = 1'b0;
        w_dly_val   = PWRUP_LD;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_PWRUP: begin
                if (w_dly_expire) begin
                    state_d = (size_q == 8'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                addr_d  = lut_data[23:8];
                data_d  = lut_data[7:0];
                retry_d = '0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i2c_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        if (needs_settle(addr_q, data_q)) begin
                            state_d     = ST_SETTLE;
                            w_dly_start = 1'b1;
                            w_dly_val   = SETTLE_LD;
                        end else begin
`ifdef I2C_CFG_READBACK_EN
                            state_d = ST_RDREQ;
`else
                            state_d = ST_NEXT;
`endif
                        end
                    end else if (w_retry_ok) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_REQ;
                    end else begin
                        err_index_d = idx_q;
                        state_d     = ST_ERR;
                    end
                end
            end
`ifdef I2C_CFG_READBACK_EN
            ST_RDREQ: begin
                if (i2c_ack) begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (i2c_done) begin
                    // A failed read-back costs one retry of the write+read pair
                    if (!i2c_nack && (i2c_rdata == data_q)) begin
                        state_d = ST_NEXT;
                    end else if (w_retry_ok) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_REQ;
                    end else begin
                        err_index_d = idx_q;
                        state_d     = ST_ERR;
                    end
                end
            end
`endif
            ST_SETTLE: begin
                if (w_dly_expire) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == (size_q - 8'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                cfg_done_d = 1'b1;
            end
            ST_ERR: begin
                cfg_err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A (re)start overrides whatever the idle/terminal states wanted
        if (w_restart) begin
            state_d     = ST_PWRUP;
            idx_d       = 8'd0;
            size_d      = lut_size;
            cfg_done_d  = 1'b0;
            cfg_err_d   = 1'b0;
            err_index_d = 8'd0;
            w_dly_start = 1'b1;
            w_dly_val   = PWRUP_LD;
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 8'd0;
            size_q      <= 8'd0;
            addr_q      <= 16'd0;
            data_q      <= 8'd0;
            retry_q     <= '0;
            err_index_q <= 8'd0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            retry_q     <= retry_d;
            err_index_q <= err_index_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef I2C_CFG_READBACK_EN
    assign i2c_req = (state_q == ST_REQ) || (state_q == ST_RDREQ);
    assign i2c_rd  = (state_q == ST_RDREQ);
`else
    logic unused_rdata;
    assign unused_rdata = ^i2c_rdata;
    assign i2c_req = (state_q == ST_REQ);
    assign i2c_rd  = 1'b0;
`endif

    assign lut_index = idx_q;
    assign i2c_addr  = addr_q;
    assign i2c_wdata = data_q;
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign err_index = err_index_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_cfg_sequencer
//  Description : Directed self-checking bench for i2c_cfg_sequencer with a
//                small LUT model and an I2C master responder (ack at once,
//                done 10 cycles later, scripted NACKs and read-back data).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cfg_sequencer;

    localparam int P = 20;
    localparam int S = 15;
`ifdef I2C_CFG_READBACK_EN
    localparam int GAP_FAST = 14;
`else
    localparam int GAP_FAST = 3;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic [7:0]  lut_size;
    logic        i2c_req;
    logic        i2c_ack;
    logic        i2c_rd;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic [7:0]  i2c_rdata;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  err_index;

    i2c_cfg_sequencer #(
        .CLK_FREQ   (25_000_000),
        .PWRUP_CYC  (P),
        .SETTLE_CYC (S),
        .MAX_RETRY  (3),
        .DLY_W      (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .lut_size  (lut_size),
        .i2c_req   (i2c_req),
        .i2c_ack   (i2c_ack),
        .i2c_rd    (i2c_rd),
        .i2c_addr  (i2c_addr),
        .i2c_wdata (i2c_wdata),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .i2c_rdata (i2c_rdata),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_index (err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Config LUT model
    logic [23:0] lut_mem [8];
    assign lut_data = (lut_index < 8'd8) ? lut_mem[lut_index[2:0]] : 24'h0;

    // Transfer log filled by the master responder
    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int          wr_cyc  [$];
    int          wr_done [$];
    int          n_rd;
    int          n_acks;
    logic [15:0] nack_addr;
    int          nack_left;
    logic        rd_bad;

    int n_checks = 0;
    int n_err    = 0;

    // I2C master responder: accept a request at once, complete 10 cycles later
    initial begin : master
        int   m_cnt;
        logic m_busy;
        logic m_nack;
        logic m_is_rd;
        logic [7:0] m_last;
        m_busy = 1'b0; m_cnt = 0; m_nack = 1'b0; m_is_rd = 1'b0; m_last = 8'h00;
        i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
        forever begin
            @(negedge clk);
            i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i2c_done  = 1'b1;
                    i2c_nack  = m_nack;
                    i2c_rdata = rd_bad ? 8'h00 : m_last;
                    m_busy    = 1'b0;
                    if (!m_is_rd) wr_done.push_back(cyc);
                end
            end else if (i2c_req) begin
                i2c_ack = 1'b1;
                m_busy  = 1'b1;
                m_cnt   = 10;
                m_is_rd = i2c_rd;
                n_acks++;
                if (!i2c_rd) begin
                    wr_addr.push_back(i2c_addr);
                    wr_data.push_back(i2c_wdata);
                    wr_cyc.push_back(cyc);
                    m_last = i2c_wdata;
                    m_nack = (i2c_addr == nack_addr) && (nack_left > 0);
                    if (m_nack) nack_left--;
                end else begin
                    n_rd++;
                    m_nack = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_done.delete();
        n_rd = 0; n_acks = 0;
    endtask

    function automatic int count_addr(input logic [15:0] a);
        int n = 0;
        foreach (wr_addr[i]) if (wr_addr[i] == a) n++;
        return n;
    endfunction

    // Pulse start for one cycle; returns the cycle number in which it was high
    task automatic pulse_start(output int scyc);
        @(negedge clk);
        start = 1'b1;
        scyc  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for cfg_done or cfg_err within a cycle budget
    task automatic wait_end(input string tag, input int budget, output int rise_cyc);
        int k = 0;
        while ((k < budget) && !(cfg_done || cfg_err)) begin
            @(negedge clk);
            k++;
        end
        rise_cyc = cyc;
        chk(tag, 32'(cfg_done || cfg_err), 32'd1);
    endtask

    initial begin : stim
        int scyc;
        int rise;
        int n;
        int acks_at_err;
        rst = 1'b1; start = 1'b0; lut_size = 8'd0;
        nack_addr = 16'h0000; nack_left = 0; rd_bad = 1'b0; n_rd = 0; n_acks = 0;
        for (int i = 0; i < 8; i++) lut_mem[i] = 24'h0;
        lut_mem[0] = 24'h0103_01;
        lut_mem[1] = 24'h3039_80;
        lut_mem[2] = 24'h3e01_40;
        lut_mem[3] = 24'h0100_01;
        repeat (3) @(negedge clk);

        // ---- reset state
        chk("rst_flags", 32'({busy, cfg_done, cfg_err, i2c_req, i2c_rd}), 32'd0);
        chk("rst_index", 32'({lut_index, err_index}), 32'd0);
        chk("rst_bus", 32'({i2c_addr, i2c_wdata}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- A: four-entry walk with settle gaps
        lut_size = 8'd4;
        clear_log();
        pulse_start(scyc);
        chk("A_busy", 32'(busy), 32'd1);
        wait_end("A_end", 2000, rise);
        chk("A_nwr", 32'(wr_addr.size()), 32'd4);
        if (wr_addr.size() == 4) begin
            chk("A_wr0", {8'h0, wr_addr[0], wr_data[0]}, 32'h0001_0301);
            chk("A_wr1", {8'h0, wr_addr[1], wr_data[1]}, 32'h0030_3980);
            chk("A_wr2", {8'h0, wr_addr[2], wr_data[2]}, 32'h003e_0140);
            chk("A_wr3", {8'h0, wr_addr[3], wr_data[3]}, 32'h0001_0001);
            chk("A_pwrup", 32'(wr_cyc[0] - scyc), 32'(P + 2));
            chk("A_gap0", 32'(wr_cyc[1] - wr_done[0]), 32'(S + 3));
            chk("A_gap1", 32'(wr_cyc[2] - wr_done[1]), 32'(GAP_FAST));
            chk("A_gap3", 32'(rise - wr_done[3]), 32'(S + 3));
        end
        chk("A_status", 32'({cfg_done, cfg_err, busy}), 32'b100);

        // ---- B: entry 2 NACKed twice, third attempt succeeds
        clear_log();
        nack_addr = 16'h3e01; nack_left = 2;
        pulse_start(scyc);
        wait_end("B_end", 2000, rise);
        chk("B_nwr", 32'(wr_addr.size()), 32'd6);
        chk("B_3e01", 32'(count_addr(16'h3e01)), 32'd3);
        chk("B_status", 32'({cfg_done, cfg_err}), 32'b10);

        // ---- C: entry 1 NACKed four times -> error
        clear_log();
        nack_addr = 16'h3039; nack_left = 4;
        pulse_start(scyc);
        wait_end("C_end", 2000, rise);
        chk("C_status", 32'({cfg_done, cfg_err}), 32'b01);
        chk("C_err_index", 32'(err_index), 32'd1);
        chk("C_3039", 32'(count_addr(16'h3039)), 32'd4);
        acks_at_err = n_acks;
        repeat (30) @(negedge clk);
        chk("C_quiet", 32'(n_acks), 32'(acks_at_err));
        chk("C_idle", 32'({i2c_req, busy, cfg_err}), 32'b001);
        nack_left = 0;

        // ---- D: empty LUT, restart from the error state
        clear_log();
        lut_size = 8'd0;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while ((n < 200) && !cfg_done) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 1) chk("D_restart", 32'({busy, cfg_err, cfg_done}), 32'b100);
        end
        chk("D_latency", 32'(n), 32'(P + 2));
        chk("D_no_xfer", 32'(n_acks), 32'd0);

        // ---- E: reset during WAIT of entry 2, then full restart
        lut_size = 8'd4;
        clear_log();
        pulse_start(scyc);
        n = 0;
        while ((n < 2000) && (wr_addr.size() < 3)) begin
            @(negedge clk);
            n++;
        end
        chk("E_reach_e2", 32'(wr_addr.size()), 32'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("E_in_rst", 32'({i2c_req, busy, cfg_done, lut_index}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start(scyc);
        wait_end("E_end", 2000, rise);
        chk("E_nwr", 32'(wr_addr.size()), 32'd4);
        if (wr_addr.size() > 0) begin
            chk("E_first", 32'(wr_addr[0]), 32'h0103);
            chk("E_pwrup", 32'(wr_cyc[0] - scyc), 32'(P + 2));
        end
        chk("E_done", 32'({cfg_done, cfg_err}), 32'b10);

`ifdef I2C_CFG_READBACK_EN
        // ---- F: read-back pass, then persistent mismatch
        lut_mem[0] = 24'h3e09_3f;
        lut_size = 8'd1;
        clear_log();
        rd_bad = 1'b0;
        pulse_start(scyc);
        wait_end("F_end_ok", 2000, rise);
        chk("F_ok", 32'({cfg_done, cfg_err}), 32'b10);
        chk("F_ok_rd", 32'(n_rd), 32'd1);
        clear_log();
        rd_bad = 1'b1;
        pulse_start(scyc);
        wait_end("F_end_bad", 2000, rise);
        chk("F_bad", 32'({cfg_done, cfg_err}), 32'b01);
        chk("F_bad_wr", 32'(wr_addr.size()), 32'd4);
        chk("F_bad_rd", 32'(n_rd), 32'd4);
        chk("F_err_index", 32'(err_index), 32'd0);
`else
        chk("no_reads", 32'(n_rd), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
